// File: rtl/sdfm_data_arb_if.sv
// sdfm_data_arb_if
// Bundles the channel capture inputs and the host read port of the
// sigma-delta result collector.
//   ch_data   : four 32-bit channel results, channel i at [32*i+31:32*i]
//   ch_update : one-cycle capture pulse per channel
//   ch_en     : per-channel enable
//   rd_en     : pop the FIFO head
//   ovr_clr   : write-1-to-clear of the sticky overrun flags
//   rd_data   : FIFO head data (0 while empty)
//   rd_ch     : FIFO head channel index (0 while empty)
//   rd_valid  : FIFO non-empty
//   level     : FIFO occupancy 0..DEPTH
//   ovr       : sticky overrun flags
//   irq       : registered interrupt, rd_valid | (|ovr)
// The slave modport is the collector; the master modport is the host/driver.
interface sdfm_data_arb_if #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
);
    logic [127:0]  ch_data;
    logic [3:0]    ch_update;
    logic [3:0]    ch_en;
    logic          rd_en;
    logic [3:0]    ovr_clr;
    logic [31:0]   rd_data;
    logic [1:0]    rd_ch;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic [3:0]    ovr;
    logic          irq;

    modport slave (
        input  ch_data, ch_update, ch_en, rd_en, ovr_clr,
        output rd_data, rd_ch, rd_valid, level, ovr, irq
    );

    modport master (
        output ch_data, ch_update, ch_en, rd_en, ovr_clr,
        input  rd_data, rd_ch, rd_valid, level, ovr, irq
    );
endinterface

// File: rtl/sdfm_data_arb.sv
// sdfm_data_arb
// Captures the results of four filter channels into per-channel holding
// registers, moves them with a round-robin arbiter into one shared
// show-ahead FIFO, and flags channels whose held result was overwritten
// before it could be queued.
//   SYSCLK : system clock, rising edge
//   SYSRST : asynchronous active-high reset
//   bus    : sdfm_data_arb_if.slave (capture inputs, host read port, flags)
module sdfm_data_arb #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic                  SYSCLK,
    input  logic                  SYSRST,
    sdfm_data_arb_if.slave        bus
);
    localparam int DATA_W = 32;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_hold [4];
    logic [3:0]        r_hv;
    logic [3:0]        r_ovr;
    logic              r_irq;
    logic [1:0]        r_ptr;
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [1:0]        r_mem_ch [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [LW-1:0]     r_level;

    logic              w_full;
    logic              w_empty;
    logic [3:0]        w_cap;
    logic              w_gnt_vld;
    logic [1:0]        w_gnt;
    logic [3:0]        w_gnt_oh;
    logic              w_push;
    logic              w_pop;
    logic [3:0]        w_hv_nxt;
    logic [3:0]        w_ovr_nxt;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_cap   = bus.ch_update & bus.ch_en;
    assign w_push  = w_gnt_vld;
    assign w_pop   = bus.rd_en & ~w_empty;

    // Arbitration: scanning from the highest offset down lets the lowest
    // offset from r_ptr overwrite, so the first requester after r_ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = 3; k >= 0; k--) begin
            if (r_hv[r_ptr + 2'(k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = r_ptr + 2'(k);
            end
        end
        // Full is judged on the current level; a same-cycle pop does not help.
        if (w_full) begin
            w_gnt_vld = 1'b0;
        end
        w_gnt_oh = w_gnt_vld ? (4'b0001 << w_gnt) : 4'b0000;
    end

    // A capture colliding with its own grant keeps hv set without an
    // overrun, since the old value leaves through the FIFO this edge.
    always_comb begin
        w_hv_nxt  = r_hv;
        w_ovr_nxt = r_ovr;
        for (int i = 0; i < 4; i++) begin
            if (!bus.ch_en[i])       w_hv_nxt[i] = 1'b0;
            else if (w_cap[i])       w_hv_nxt[i] = 1'b1;
            else if (w_gnt_oh[i])    w_hv_nxt[i] = 1'b0;

            if (w_cap[i] && r_hv[i] && !w_gnt_oh[i]) w_ovr_nxt[i] = 1'b1;
            else if (bus.ovr_clr[i])                 w_ovr_nxt[i] = 1'b0;
        end
    end

    // Capture / control stage
    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            for (int i = 0; i < 4; i++) r_hold[i] <= '0;
            r_hv    <= '0;
            r_ovr   <= '0;
            r_irq   <= 1'b0;
            r_ptr   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_cap[i]) r_hold[i] <= bus.ch_data[DATA_W*i +: DATA_W];
            end
            r_hv  <= w_hv_nxt;
            r_ovr <= w_ovr_nxt;
            r_irq <= ~w_empty | (|r_ovr);
            if (w_push) begin
                r_ptr <= w_gnt + 2'd1;
                r_wp  <= r_wp + AW'(1);
            end
            if (w_pop) r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage stage; contents are unreachable while empty, so no reset
    always_ff @(posedge SYSCLK) begin
        if (w_push) begin
            r_mem_data[r_wp] <= r_hold[w_gnt];
            r_mem_ch[r_wp]   <= w_gnt;
        end
    end

    assign bus.rd_data  = w_empty ? '0 : r_mem_data[r_rp];
    assign bus.rd_ch    = w_empty ? '0 : r_mem_ch[r_rp];
    assign bus.rd_valid = ~w_empty;
    assign bus.level    = r_level;
    assign bus.ovr      = r_ovr;
    assign bus.irq      = r_irq;
endmodule

// File: tb/tb_sdfm_data_arb.sv
// tb_sdfm_data_arb
// Directed bench for sdfm_data_arb: reset/single read, round-robin order
// with a full FIFO, overrun, capture/grant collision, enable and empty pop,
// and asynchronous reset mid-operation.
module tb_sdfm_data_arb;
    logic SYSCLK = 1'b0;
    logic SYSRST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sdfm_data_arb_if #(.DEPTH(4), .LW(3)) bus ();

    sdfm_data_arb #(.DEPTH(4), .LW(3)) dut (
        .SYSCLK (SYSCLK),
        .SYSRST (SYSRST),
        .bus    (bus)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic step();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] v);
        bus.ch_data[32*i +: 32] = v;
    endtask

    task automatic do_reset();
        SYSRST = 1'b1;
        bus.ch_update = '0;
        bus.rd_en = 1'b0;
        bus.ovr_clr = '0;
        bus.ch_en = 4'hF;
        step();
        SYSRST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (bus.level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", bus.level); end
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0 || bus.rd_ch !== 2'd0) begin
            errors++; $display("FAIL rst_head: got v=%b d=%h c=%0d want 0/0/0", bus.rd_valid, bus.rd_data, bus.rd_ch); end
        checks++;
        if (bus.ovr !== 4'h0 || bus.irq !== 1'b0) begin
            errors++; $display("FAIL rst_flags: got ovr=%b irq=%b want 0/0", bus.ovr, bus.irq); end
        checks++;
        set_ch(0, 32'h1234_5678);
        bus.ch_update = 4'b0001;
        step();
        bus.ch_update = '0;
        if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_early: got rd_valid=%b want 0", bus.rd_valid); end
        checks++;
        step();
        if (bus.rd_valid !== 1'b1 || bus.rd_ch !== 2'd0 || bus.rd_data !== 32'h1234_5678 || bus.level !== 3'd1) begin
            errors++; $display("FAIL single_head: got v=%b c=%0d d=%h l=%0d want 1/0/12345678/1",
                               bus.rd_valid, bus.rd_ch, bus.rd_data, bus.level); end
        checks++;
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL single_irq_early: got %b want 0", bus.irq); end
        checks++;
        step();
        if (bus.irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b want 1", bus.irq); end
        checks++;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        if (bus.level !== 3'd0 || bus.rd_valid !== 1'b0 || bus.irq !== 1'b1) begin
            errors++; $display("FAIL single_pop: got l=%0d v=%b irq=%b want 0/0/1", bus.level, bus.rd_valid, bus.irq); end
        checks++;
        step();
        if (bus.irq !== 1'b0) begin errors++; $display("FAIL single_irq_drop: got %b want 0", bus.irq); end
        checks++;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ch [4];
        logic [31:0] exp_d  [4];
        exp_ch = '{2'd1, 2'd2, 2'd3, 2'd1};
        exp_d  = '{32'hA1, 32'hA2, 32'hA3, 32'hB1};
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + i);
        bus.ch_update = 4'hF;
        step();
        bus.ch_update = '0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (bus.level !== 3'(i) || bus.rd_ch !== 2'd0 || bus.rd_data !== 32'hA0) begin
                errors++; $display("FAIL rr_fill%0d: got l=%0d c=%0d d=%h want %0d/0/a0",
                                   i, bus.level, bus.rd_ch, bus.rd_data, i); end
            checks++;
        end
        set_ch(1, 32'hB1);
        bus.ch_update = 4'b0010;
        step();
        bus.ch_update = '0;
        step();
        if (bus.level !== 3'd4) begin errors++; $display("FAIL rr_full_hold: got l=%0d want 4", bus.level); end
        checks++;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        if (bus.level !== 3'd3) begin errors++; $display("FAIL rr_pop_nopush: got l=%0d want 3", bus.level); end
        checks++;
        step();
        if (bus.level !== 3'd4) begin errors++; $display("FAIL rr_late_push: got l=%0d want 4", bus.level); end
        checks++;
        for (int i = 0; i < 4; i++) begin
            if (bus.rd_ch !== exp_ch[i] || bus.rd_data !== exp_d[i]) begin
                errors++; $display("FAIL rr_order%0d: got c=%0d d=%h want c=%0d d=%h",
                                   i, bus.rd_ch, bus.rd_data, exp_ch[i], exp_d[i]); end
            checks++;
            bus.rd_en = 1'b1;
            step();
        end
        bus.rd_en = 1'b0;
        if (bus.level !== 3'd0 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL rr_drained: got l=%0d v=%b want 0/0", bus.level, bus.rd_valid); end
        checks++;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 32'hC0 + i);
        bus.ch_update = 4'hF;
        step();
        bus.ch_update = '0;
        repeat (4) step();
        set_ch(2, 32'h11);
        bus.ch_update = 4'b0100;
        step();
        if (bus.ovr !== 4'b0000) begin errors++; $display("FAIL ovr_first: got %b want 0000", bus.ovr); end
        checks++;
        set_ch(2, 32'h22);
        step();
        bus.ch_update = '0;
        if (bus.ovr !== 4'b0100 || bus.level !== 3'd4) begin
            errors++; $display("FAIL ovr_set: got ovr=%b l=%0d want 0100/4", bus.ovr, bus.level); end
        checks++;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        step();
        if (bus.level !== 3'd4) begin errors++; $display("FAIL ovr_refill: got l=%0d want 4", bus.level); end
        checks++;
        bus.rd_en = 1'b1;
        repeat (3) step();
        bus.rd_en = 1'b0;
        if (bus.rd_ch !== 2'd2 || bus.rd_data !== 32'h22 || bus.level !== 3'd1) begin
            errors++; $display("FAIL ovr_newest: got c=%0d d=%h l=%0d want 2/22/1", bus.rd_ch, bus.rd_data, bus.level); end
        checks++;
        bus.ovr_clr = 4'b0100;
        step();
        bus.ovr_clr = '0;
        if (bus.ovr !== 4'b0000) begin errors++; $display("FAIL ovr_clear: got %b want 0000", bus.ovr); end
        checks++;
    endtask

    task automatic test_collide();
        do_reset();
        set_ch(3, 32'h55);
        bus.ch_update = 4'b1000;
        step();
        set_ch(3, 32'h66);
        step();
        bus.ch_update = '0;
        if (bus.level !== 3'd1 || bus.rd_ch !== 2'd3 || bus.rd_data !== 32'h55 || bus.ovr !== 4'h0) begin
            errors++; $display("FAIL col_first: got l=%0d c=%0d d=%h ovr=%b want 1/3/55/0000",
                               bus.level, bus.rd_ch, bus.rd_data, bus.ovr); end
        checks++;
        step();
        if (bus.level !== 3'd2) begin errors++; $display("FAIL col_second_push: got l=%0d want 2", bus.level); end
        checks++;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        if (bus.rd_ch !== 2'd3 || bus.rd_data !== 32'h66 || bus.ovr !== 4'h0) begin
            errors++; $display("FAIL col_second: got c=%0d d=%h ovr=%b want 3/66/0000", bus.rd_ch, bus.rd_data, bus.ovr); end
        checks++;
    endtask

    task automatic test_enable_empty_pop();
        do_reset();
        bus.ch_en = 4'b1101;
        set_ch(1, 32'h77);
        bus.ch_update = 4'b0010;
        step();
        bus.ch_update = '0;
        repeat (2) step();
        if (bus.level !== 3'd0 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL en_ignored: got l=%0d v=%b want 0/0", bus.level, bus.rd_valid); end
        checks++;
        bus.ch_en = 4'hF;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        if (bus.level !== 3'd0 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL empty_pop: got l=%0d v=%b want 0/0", bus.level, bus.rd_valid); end
        checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 32'hD0 + i);
        bus.ch_update = 4'hF;
        step();
        bus.ch_update = '0;
        repeat (4) step();
        set_ch(0, 32'hE0);
        set_ch(2, 32'hE2);
        bus.ch_update = 4'b0101;
        repeat (2) step();
        bus.ch_update = '0;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        if (bus.level !== 3'd3 || bus.ovr !== 4'b0101) begin
            errors++; $display("FAIL arst_setup: got l=%0d ovr=%b want 3/0101", bus.level, bus.ovr); end
        checks++;
        #3;
        SYSRST = 1'b1;
        #1;
        if (bus.level !== 3'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0 || bus.rd_ch !== 2'd0 ||
            bus.ovr !== 4'h0 || bus.irq !== 1'b0) begin
            errors++; $display("FAIL arst_now: got l=%0d v=%b d=%h c=%0d ovr=%b irq=%b want all 0",
                               bus.level, bus.rd_valid, bus.rd_data, bus.rd_ch, bus.ovr, bus.irq); end
        checks++;
        step();
        SYSRST = 1'b0;
    endtask

    initial begin
        bus.ch_data   = '0;
        bus.ch_update = '0;
        bus.ch_en     = 4'hF;
        bus.rd_en     = 1'b0;
        bus.ovr_clr   = '0;
        test_reset();
        test_round_robin();
        test_overrun();
        test_collide();
        test_enable_empty_pop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
